// File: rtl/factor_out_seq.sv
// factor_out_seq: 16-entry factor bank that is filled by single writes and
// then scanned out one entry per downstream accept through an external
// 16:1 mux driven by OutMuxAdd.
module factor_out_seq #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [SIZE-1:0] wr_data,
  input  logic            rd_start,
  input  logic            out_ready,
  output logic [SIZE-1:0] x0,
  output logic [SIZE-1:0] x1,
  output logic [SIZE-1:0] x2,
  output logic [SIZE-1:0] x3,
  output logic [SIZE-1:0] x4,
  output logic [SIZE-1:0] x5,
  output logic [SIZE-1:0] x6,
  output logic [SIZE-1:0] x7,
  output logic [SIZE-1:0] x8,
  output logic [SIZE-1:0] x9,
  output logic [SIZE-1:0] x10,
  output logic [SIZE-1:0] x11,
  output logic [SIZE-1:0] x12,
  output logic [SIZE-1:0] x13,
  output logic [SIZE-1:0] x14,
  output logic [SIZE-1:0] x15,
  output logic [3:0]      OutMuxAdd,
  output logic            out_valid,
  output logic            out_last,
  output logic [4:0]      count,
  output logic            full,
  output logic            busy,
  output logic            done,
  output logic            wr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [SIZE-1:0] bank_q [16];
  logic [4:0]      count_q;
  logic [4:0]      count_d;
  logic [3:0]      idx_q;
  logic            valid_q;
  logic            done_q;
  logic            wr_err_q;
  logic            full_w;
  logic            last_w;
  logic            wr_ok;
  logic            wr_drop;

  assign full_w = (count_q == 5'd16);
  // In SCAN the count is always non-zero, so count_q-1 never underflows there.
  assign last_w = (state_q == SCAN) && ({1'b0, idx_q} == (count_q - 5'd1));

  // Classify the write strobe and compute the post-write count that a
  // simultaneous rd_start must see.
  always_comb begin
    wr_ok   = 1'b0;
    wr_drop = 1'b0;
    count_d = count_q;
    if (!clr && wr_en) begin
      if (state_q == IDLE && !full_w) begin
        wr_ok   = 1'b1;
        count_d = count_q + 5'd1;
      end else begin
        wr_drop = 1'b1;
      end
    end
  end

  // Controller FSM, bank storage and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      wr_err_q <= wr_drop;
      if (wr_ok) begin
        bank_q[count_q[3:0]] <= wr_data;
      end
      if (clr) begin
        state_q <= IDLE;
        count_q <= '0;
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        count_q <= count_d;
        case (state_q)
          IDLE: begin
            if (rd_start) begin
              idx_q <= '0;
              if (count_d != 5'd0) begin
                state_q <= SCAN;
                valid_q <= 1'b1;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end
            end
          end
          SCAN: begin
            if (out_ready) begin
              if (last_w) begin
                state_q <= DONE;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign x0  = bank_q[0];
  assign x1  = bank_q[1];
  assign x2  = bank_q[2];
  assign x3  = bank_q[3];
  assign x4  = bank_q[4];
  assign x5  = bank_q[5];
  assign x6  = bank_q[6];
  assign x7  = bank_q[7];
  assign x8  = bank_q[8];
  assign x9  = bank_q[9];
  assign x10 = bank_q[10];
  assign x11 = bank_q[11];
  assign x12 = bank_q[12];
  assign x13 = bank_q[13];
  assign x14 = bank_q[14];
  assign x15 = bank_q[15];

  assign OutMuxAdd = idx_q;
  assign out_valid = valid_q;
  assign out_last  = last_w;
  assign count     = count_q;
  assign full      = full_w;
  assign busy      = (state_q == SCAN);
  assign done      = done_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_factor_out_seq.sv
// Directed bench for factor_out_seq with a scoreboard of expected scan entries.
module tb_factor_out_seq;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst_n, clr, wr_en, rd_start, out_ready;
  logic [SIZE-1:0] wr_data;
  logic [SIZE-1:0] xs [16];
  logic [3:0]      OutMuxAdd;
  logic            out_valid, out_last, full, busy, done, wr_err;
  logic [4:0]      count;

  typedef struct packed {
    logic [3:0]      idx;
    logic [SIZE-1:0] val;
  } ent_t;

  ent_t            exp_q [$];
  logic [SIZE-1:0] mbank [16];
  int unsigned     mcount;
  int unsigned     checks = 0;
  int unsigned     errors = 0;

  always #5 clk = ~clk;

  factor_out_seq #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_start(rd_start), .out_ready(out_ready),
    .x0(xs[0]), .x1(xs[1]), .x2(xs[2]), .x3(xs[3]),
    .x4(xs[4]), .x5(xs[5]), .x6(xs[6]), .x7(xs[7]),
    .x8(xs[8]), .x9(xs[9]), .x10(xs[10]), .x11(xs[11]),
    .x12(xs[12]), .x13(xs[13]), .x14(xs[14]), .x15(xs[15]),
    .OutMuxAdd(OutMuxAdd), .out_valid(out_valid), .out_last(out_last),
    .count(count), .full(full), .busy(busy), .done(done), .wr_err(wr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [SIZE-1:0] v);
    bit drop;
    drop = (mcount == 16);
    wr_en = 1'b1; wr_data = v;
    tick();
    wr_en = 1'b0;
    if (!drop) begin
      mbank[mcount] = v;
      mcount++;
    end
    chk("wr_count", count, mcount);
    chk("wr_err", wr_err, drop);
  endtask

  task automatic push_scan();
    for (int unsigned i = 0; i < mcount; i++) exp_q.push_back({4'(i), mbank[i]});
  endtask

  task automatic start_scan();
    push_scan();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mcount = 0;
    exp_q.delete();
    chk("clr_count", count, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_idx", OutMuxAdd, 0);
  endtask

  // Present/accept loop: ready follows pat bits cyclically over plen cycles.
  task automatic drain(input logic [7:0] pat, input int unsigned plen);
    int unsigned k = 0;
    int unsigned guard = 0;
    logic r;
    while (exp_q.size() > 0 && guard < 200) begin
      chk("valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("idx", OutMuxAdd, exp_q[0].idx);
      chk("data", xs[OutMuxAdd], exp_q[0].val);
      chk("last", out_last, exp_q.size() == 1);
      r = pat[k % plen];
      k++;
      out_ready = r;
      tick();
      if (r) void'(exp_q.pop_front());
      guard++;
    end
    out_ready = 1'b0;
    chk("drain_timeout", exp_q.size(), 0);
    chk("done_pulse", done, 1);
    chk("valid_off", out_valid, 0);
    chk("busy_off", busy, 0);
    tick();
    chk("done_once", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_start = 1'b0; out_ready = 1'b0;
    wr_data = '0; mcount = 0;
    for (int i = 0; i < 16; i++) mbank[i] = '0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_done", done, 0);
    chk("rst_x0", xs[0], 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);

    // Basic fill and scan with continuous accept; untouched entries read 0.
    wr(8'd3); wr(8'd5); wr(8'd7);
    chk("unwritten_x3", xs[3], 0);
    start_scan();
    drain(8'hff, 1);

    // Rescan re-emits the same data with a stalling consumer.
    chk("persist_count", count, 3);
    start_scan();
    drain(8'b0110, 4);

    // Empty scan goes straight to DONE.
    do_clr();
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("empty_valid", out_valid, 0);
    chk("empty_done", done, 1);
    tick();
    chk("empty_done_once", done, 0);
    chk("empty_valid2", out_valid, 0);

    // Two entries, ready pattern 0,1,0,0,1.
    do_clr();
    wr(8'hA1); wr(8'hB2);
    start_scan();
    drain(8'b10010, 5);

    // clr mid-scan at index 1 of 4 aborts without done.
    do_clr();
    wr(8'd11); wr(8'd22); wr(8'd33); wr(8'd44);
    start_scan();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("abort_idx", OutMuxAdd, 1);
    do_clr();
    chk("abort_done", done, 0);
    tick();
    chk("abort_done2", done, 0);

    // Fill to 16, overflow write dropped.
    for (int i = 1; i <= 16; i++) wr(8'(i));
    chk("full", full, 1);
    wr(8'd99);
    chk("x15_kept", xs[15], 16);
    tick();
    chk("wr_err_once", wr_err, 0);

    // Full scan while writes arrive during SCAN (dropped).
    start_scan();
    wr_en = 1'b1; wr_data = 8'd77;
    tick();
    wr_en = 1'b0;
    chk("scan_wr_err", wr_err, 1);
    chk("scan_wr_count", count, 16);
    drain(8'hff, 1);

    // Write and rd_start together: scan includes the new entry.
    do_clr();
    wr(8'd10);
    mbank[1] = 8'd20;
    mcount = 2;
    push_scan();
    wr_en = 1'b1; wr_data = 8'd20; rd_start = 1'b1;
    tick();
    wr_en = 1'b0; rd_start = 1'b0;
    chk("combo_count", count, 2);
    drain(8'b0110, 4);

    // Asynchronous reset mid-scan.
    wr(8'd55);
    start_scan();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", count, 0);
    chk("arst_x0", xs[0], 0);
    chk("arst_x2", xs[2], 0);
    exp_q.delete();
    mcount = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_no_done", done, 0);
    tick();
    chk("arst_no_done2", done, 0);
    chk("arst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
